// File: rtl/prog_tick_divider.sv
// Runtime-programmable tick divider: one-cycle tick strobe plus a pulse or square clk_out.
// Divisor updates are double-buffered and applied only at a period boundary or on restart.
module prog_tick_divider #(
   parameter int unsigned CNT_W       = 21,
   parameter int unsigned DEFAULT_DIV = 20000,
   parameter int unsigned TCNT_W      = 16
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              en,
   input  logic              restart,
   input  logic              div_load,
   input  logic [CNT_W-1:0]  div_in,
   input  logic              mode_in,
   output logic              tick_out,
   output logic              clk_out,
   output logic              div_pending,
   output logic              div_err,
   output logic [TCNT_W-1:0] tick_cnt
);

   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  r_div_active;
   logic [CNT_W-1:0]  r_div_next;
   logic              r_div_pending;
   logic              r_mode_active;
   logic              r_tick;
   logic              r_clk;
   logic              r_div_err;
   logic [TCNT_W-1:0] r_tick_cnt;

   logic              w_div_ok;
   logic              w_term;

   assign w_div_ok = div_load && (div_in >= CNT_W'(2));
   assign w_term   = en && (r_count == (r_div_active - CNT_W'(1)));

   always_ff @(posedge clk_in) begin
      if (rst) begin
         r_count       <= '0;
         r_div_active  <= CNT_W'(DEFAULT_DIV);
         r_div_next    <= '0;
         r_div_pending <= 1'b0;
         r_mode_active <= 1'b0;
         r_tick        <= 1'b0;
         r_clk         <= 1'b0;
         r_div_err     <= 1'b0;
         r_tick_cnt    <= '0;
      end else begin
         r_div_err <= div_load && !w_div_ok;
         if (restart) begin
            r_count       <= '0;
            r_tick        <= 1'b0;
            r_clk         <= 1'b0;
            r_tick_cnt    <= '0;
            r_mode_active <= mode_in;
            // A valid load coinciding with restart bypasses the pending buffer.
            if (w_div_ok) begin
               r_div_active  <= div_in;
               r_div_pending <= 1'b0;
            end else if (r_div_pending) begin
               r_div_active  <= r_div_next;
               r_div_pending <= 1'b0;
            end
         end else begin
            if (w_term) begin
               r_count       <= '0;
               r_tick        <= 1'b1;
               r_tick_cnt    <= r_tick_cnt + TCNT_W'(1);
               r_mode_active <= mode_in;
               r_clk         <= mode_in ? ~r_clk : 1'b1;
               if (r_div_pending) begin
                  r_div_active  <= r_div_next;
                  r_div_pending <= 1'b0;
               end
            end else begin
               if (en) begin
                  r_count <= r_count + CNT_W'(1);
               end
               r_tick <= 1'b0;
               if (!r_mode_active) begin
                  r_clk <= 1'b0;
               end
            end
            // Placed after the boundary update so a load at terminal count stays pending.
            if (w_div_ok) begin
               r_div_next    <= div_in;
               r_div_pending <= 1'b1;
            end
         end
      end
   end

   assign tick_out    = r_tick;
   assign clk_out     = r_clk;
   assign div_pending = r_div_pending;
   assign div_err     = r_div_err;
   assign tick_cnt    = r_tick_cnt;

endmodule
